fp_writeback_arbiter: RTL and testbench
=======================================

// Module: fp_writeback_arbiter
// PURPOSE
//  Single-write-port arbiter in front of the FP register file. Merges single-cycle
//  FP pipeline results (FLW, FADD, FMV...) with results from the long-latency FP unit
//  (FDIV/FSQRT). Buffers long results in a small FIFO. Keeps a pending-destination
//  scoreboard so decode can stall on RAW/WAW hazards against outstanding long ops.
// PARAMETERS
//  FIFO_DEPTH  4   long-result FIFO entries; power of 2, >=2
//  DATA_W      32  FP data width
//  REG_AW      5   register address width (32 FP registers)
// PORTS
//  iCLK            in   1       core clock; all state updates on posedge
//  iRST_N          in   1       asynchronous, active-low reset
//  iPipeWrite      in   1       single-cycle result write request; always accepted
//  iPipeReg        in   REG_AW  destination of pipeline write
//  iPipeData       in   DATA_W  pipeline write data
//  iLongValid      in   1       long-latency result valid
//  iLongReg        in   REG_AW  destination of long result
//  iLongData       in   DATA_W  long result data
//  oLongReady      out  1       FIFO can accept; transfer when iLongValid & oLongReady
//  iIssueLong      in   1       long op issued this cycle; marks iIssueReg pending
//  iIssueReg       in   REG_AW  destination of issued long op
//  iCheckReg1/2/D  in   REG_AW  rs1, rs2, rd of instruction in decode
//  oHazard         out  1       pending[rs1] | pending[rs2] | pending[rd]
//  oRegWrite       out  1       write enable to FP register file (registered)
//  oWriteRegister  out  REG_AW  write address (registered)
//  oWriteData      out  DATA_W  write data (registered)
//  oFifoCount      out  log2(FIFO_DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  - Reset (iRST_N=0, immediate): oRegWrite=0, oWriteRegister=0, oWriteData=0, FIFO
//    empty (oFifoCount=0), all pending bits 0, oLongReady=0. Reset mid-operation drops
//    all buffered results and pending marks. oLongReady=1 from first edge after release.
//  - oLongReady = !full (oFifoCount < FIFO_DEPTH); registered state only, no
//    combinational path from iLongValid or from dequeue.
//  - Output register loaded every posedge, priority:
//    1) iPipeWrite: oRegWrite=1, reg/data from pipe port; latency 1 cycle.
//    2) else FIFO non-empty: dequeue head, oRegWrite=1; clear pending[head.reg].
//    3) else oRegWrite=0; oWriteRegister/oWriteData hold previous values.
//  - Long results enqueued at tail on accept; latency >=2 cycles (enqueue, then drain).
//  - Simultaneous enqueue and dequeue: both happen, count unchanged; pointers wrap
//    modulo FIFO_DEPTH. Enqueue into empty FIFO is not visible to dequeue same cycle.
//  - FIFO order preserved; pipe writes may starve FIFO while iPipeWrite stays high.
//  - Scoreboard: 2^REG_AW bits. Set on iIssueLong; cleared on dequeue of that reg.
//    Set and clear of the same reg in one cycle: set wins (newer op).
//  - oHazard combinational from pending bits (registered) and check ports; no
//    bypass of a same-cycle clear. Decode must stall while oHazard=1, so at most one
//    outstanding long op per destination.
//  - oFifoCount reflects registered state; never exceeds FIFO_DEPTH.
// CONFIGURATION
//  FP_WB_BYPASS_EN defined: when iLongValid & !iPipeWrite & FIFO empty, the long result
//    goes straight to the output register (latency 1), is not enqueued, and its pending
//    bit is cleared that edge; oLongReady unchanged.
//  Undefined: all long results pass through the FIFO (latency >=2).
// TESTING
//  1 Reset: hold iRST_N=0 2 cycles with random inputs -> oRegWrite=0, oFifoCount=0,
//    oLongReady=0, oHazard=0; release -> oLongReady=1 next edge.
//  2 iPipeWrite reg=3 data=32'h3F800000 -> next edge oRegWrite=1, f3, 3F800000; then 0.
//  3 Issue long f5, then iLongValid f5 data=40490FDB with iPipeWrite=0 -> FIFO count 1,
//    write f5 one cycle later (bypass build: same edge), oHazard for rs1=5 drops after.
//  4 Hold iPipeWrite=1 while 5 long results arrive (DEPTH=4) -> 4 accepted, oLongReady=0,
//    5th stalled; drop iPipeWrite -> 4 writes in FIFO order, ready returns after first.
//  5 Same-cycle iIssueLong f7 and dequeue of old f7 entry -> pending[7] stays 1.
//  6 Assert iRST_N=0 with 3 entries buffered -> count 0, no further writes, pending 0.

Source files
------------

// File: rtl/fp_writeback_arbiter.sv
// fp_writeback_arbiter: FP regfile write-port arbiter with long-result FIFO and pending scoreboard (option FP_WB_BYPASS_EN)
module fp_writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic                          iPipeWrite,
  input  logic [REG_AW-1:0]             iPipeReg,
  input  logic [DATA_W-1:0]             iPipeData,
  input  logic                          iLongValid,
  input  logic [REG_AW-1:0]             iLongReg,
  input  logic [DATA_W-1:0]             iLongData,
  output logic                          oLongReady,
  input  logic                          iIssueLong,
  input  logic [REG_AW-1:0]             iIssueReg,
  input  logic [REG_AW-1:0]             iCheckReg1,
  input  logic [REG_AW-1:0]             iCheckReg2,
  input  logic [REG_AW-1:0]             iCheckRegD,
  output logic                          oHazard,
  output logic                          oRegWrite,
  output logic [REG_AW-1:0]             oWriteRegister,
  output logic [DATA_W-1:0]             oWriteData,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = REG_AW + DATA_W;
  localparam int NR = 1 << REG_AW;
  localparam logic [PW:0] FULL = FIFO_DEPTH[PW:0];
  typedef logic [EW-1:0] entry_t;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [NR-1:0]     pending_q, pending_d;
  logic              rdy_q;
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              empty, accept, byp, enq, deq;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  assign empty      = count_q == '0;
  // rdy_q keeps ready low until the first edge after reset release
  assign oLongReady = rdy_q & (count_q != FULL);
  assign head_reg   = mem_q[rd_ptr_q][EW-1:DATA_W];
  assign head_data  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign oHazard    = pending_q[iCheckReg1] | pending_q[iCheckReg2] | pending_q[iCheckRegD];
  assign oRegWrite      = reg_write_q;
  assign oWriteRegister = write_reg_q;
  assign oWriteData     = write_data_q;
  assign oFifoCount     = count_q;
  // Arbitration, FIFO pointer/count update and scoreboard next state (issue set beats dequeue clear)
  always_comb begin
    accept = iLongValid & oLongReady;
`ifdef FP_WB_BYPASS_EN
    byp = accept & ~iPipeWrite & empty;
`else
    byp = 1'b0;
`endif
    enq = accept & ~byp;
    deq = ~iPipeWrite & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    pending_d = pending_q;
    if (enq) mem_d[wr_ptr_q] = {iLongReg, iLongData};
    if (deq) pending_d[head_reg] = 1'b0;
    if (byp) pending_d[iLongReg] = 1'b0;
    if (iIssueLong) pending_d[iIssueReg] = 1'b1;
    reg_write_d  = iPipeWrite | deq | byp;
    write_reg_d  = iPipeWrite ? iPipeReg  : deq ? head_reg  : byp ? iLongReg  : write_reg_q;
    write_data_d = iPipeWrite ? iPipeData : deq ? head_data : byp ? iLongData : write_data_q;
  end
  // State registers; reset discards buffered results and pending marks
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      rdy_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      rdy_q        <= 1'b1;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end
endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// tb_fp_writeback_arbiter: vector table plus write scoreboard for fp_writeback_arbiter
module tb_fp_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pw, lv, lrdy, iss, haz, we;
  logic [4:0]  preg, lreg, ireg, c1, c2, cd, wreg;
  logic [31:0] pdata, ldata, wdata;
  logic [2:0]  cnt;
  int          n_chk = 0;
  int          n_err = 0;
  logic [36:0] sb[$];

  typedef struct {
    logic pw; logic [4:0] preg; logic [31:0] pdata;
    logic lv; logic [4:0] lreg; logic [31:0] ldata;
    logic iss; logic [4:0] ireg; logic [4:0] c1, c2, cd;
    logic we; logic [4:0] wreg; logic [31:0] wdata;
    logic [2:0] cnt; logic rdy; logic haz;
  } vec_t;
  vec_t vecs[$];

  fp_writeback_arbiter #(.FIFO_DEPTH(4), .DATA_W(32), .REG_AW(5)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iPipeWrite(pw), .iPipeReg(preg), .iPipeData(pdata),
    .iLongValid(lv), .iLongReg(lreg), .iLongData(ldata), .oLongReady(lrdy),
    .iIssueLong(iss), .iIssueReg(ireg),
    .iCheckReg1(c1), .iCheckReg2(c2), .iCheckRegD(cd), .oHazard(haz),
    .oRegWrite(we), .oWriteRegister(wreg), .oWriteData(wdata), .oFifoCount(cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic a_pw, input logic [4:0] a_preg, input logic [31:0] a_pdata,
                              input logic a_lv, input logic [4:0] a_lreg, input logic [31:0] a_ldata,
                              input logic a_iss, input logic [4:0] a_ireg,
                              input logic [4:0] a_c1, input logic [4:0] a_c2, input logic [4:0] a_cd,
                              input logic a_we, input logic [4:0] a_wreg, input logic [31:0] a_wdata,
                              input logic [2:0] a_cnt, input logic a_rdy, input logic a_haz);
    vec_t v;
    v.pw = a_pw; v.preg = a_preg; v.pdata = a_pdata;
    v.lv = a_lv; v.lreg = a_lreg; v.ldata = a_ldata;
    v.iss = a_iss; v.ireg = a_ireg; v.c1 = a_c1; v.c2 = a_c2; v.cd = a_cd;
    v.we = a_we; v.wreg = a_wreg; v.wdata = a_wdata;
    v.cnt = a_cnt; v.rdy = a_rdy; v.haz = a_haz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pw = 0; preg = 0; pdata = 0; lv = 0; lreg = 0; ldata = 0;
    iss = 0; ireg = 0; c1 = 0; c2 = 0; cd = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [36:0] e;
    pw = v.pw; preg = v.preg; pdata = v.pdata;
    lv = v.lv; lreg = v.lreg; ldata = v.ldata;
    iss = v.iss; ireg = v.ireg; c1 = v.c1; c2 = v.c2; cd = v.cd;
    if (v.we) sb.push_back({v.wreg, v.wdata});
    @(posedge clk); #1;
    chk($sformatf("v%0d_regwrite", idx), {31'd0, we}, {31'd0, v.we});
    if (we) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL v%0d_unexpected_write: got f%0d=%h expected no write", idx, wreg, wdata);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_wreg", idx), {27'd0, wreg}, {27'd0, e[36:32]});
        chk($sformatf("v%0d_wdata", idx), wdata, e[31:0]);
      end
    end else begin
      if (v.we && sb.size() > 0) void'(sb.pop_back());
      chk($sformatf("v%0d_hold_reg", idx), {27'd0, wreg}, {27'd0, v.wreg});
      chk($sformatf("v%0d_hold_data", idx), wdata, v.wdata);
    end
    chk($sformatf("v%0d_count", idx), {29'd0, cnt}, {29'd0, v.cnt});
    chk($sformatf("v%0d_ready", idx), {31'd0, lrdy}, {31'd0, v.rdy});
    chk($sformatf("v%0d_hazard", idx), {31'd0, haz}, {31'd0, v.haz});
  endtask

  initial begin
    //             pw preg pdata          lv lreg ldata          is ir  c1 c2 cd  we wr wdata          cn rdy hz
    vecs.push_back(mk(1, 3, 32'h3F800000, 0, 0, 0,             0, 0,  0, 0, 0,  1, 3, 32'h3F800000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  0, 0, 0,  0, 3, 32'h3F800000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             1, 5,  0, 5, 0,  0, 3, 32'h3F800000, 0, 1, 1));
`ifdef FP_WB_BYPASS_EN
    vecs.push_back(mk(0, 0, 0,            1, 5, 32'h40490FDB,  0, 0,  0, 0, 5,  1, 5, 32'h40490FDB, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  5, 0, 0,  0, 5, 32'h40490FDB, 0, 1, 0));
`else
    vecs.push_back(mk(0, 0, 0,            1, 5, 32'h40490FDB,  0, 0,  0, 0, 5,  0, 3, 32'h3F800000, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  5, 0, 0,  1, 5, 32'h40490FDB, 0, 1, 0));
`endif
    vecs.push_back(mk(1, 1, 32'd1,        1, 10, 32'hA0000000, 0, 0,  0, 0, 0,  1, 1, 32'd1,        1, 1, 0));
    vecs.push_back(mk(1, 1, 32'd2,        1, 11, 32'hA0000001, 0, 0,  0, 0, 0,  1, 1, 32'd2,        2, 1, 0));
    vecs.push_back(mk(1, 1, 32'd3,        1, 12, 32'hA0000002, 0, 0,  0, 0, 0,  1, 1, 32'd3,        3, 1, 0));
    vecs.push_back(mk(1, 1, 32'd4,        1, 13, 32'hA0000003, 0, 0,  0, 0, 0,  1, 1, 32'd4,        4, 0, 0));
    vecs.push_back(mk(1, 1, 32'd5,        1, 14, 32'hA0000004, 0, 0,  0, 0, 0,  1, 1, 32'd5,        4, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 14, 32'hA0000004, 0, 0,  0, 0, 0,  1, 10, 32'hA0000000, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 14, 32'hA0000004, 0, 0,  0, 0, 0,  1, 11, 32'hA0000001, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  0, 0, 0,  1, 12, 32'hA0000002, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  0, 0, 0,  1, 13, 32'hA0000003, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  0, 0, 0,  1, 14, 32'hA0000004, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  0, 0, 0,  0, 14, 32'hA0000004, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             1, 7,  7, 0, 0,  0, 14, 32'hA0000004, 0, 1, 1));
    vecs.push_back(mk(1, 2, 32'h22,       1, 7, 32'h77,        0, 0,  7, 0, 0,  1, 2, 32'h22,       1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             1, 7,  7, 0, 0,  1, 7, 32'h77,       0, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  7, 0, 0,  0, 7, 32'h77,       0, 1, 1));
    vecs.push_back(mk(1, 2, 32'h33,       1, 7, 32'h78,        0, 0,  7, 0, 0,  1, 2, 32'h33,       1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,             0, 0,  7, 0, 0,  1, 7, 32'h78,       0, 1, 0));

    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      pw = 1'($urandom); preg = 5'($urandom); pdata = $urandom;
      lv = 1'($urandom); lreg = 5'($urandom); ldata = $urandom;
      iss = 1'($urandom); ireg = 5'($urandom);
      c1 = 5'($urandom); c2 = 5'($urandom); cd = 5'($urandom);
      @(posedge clk); #1;
      chk($sformatf("rst%0d_regwrite", i), {31'd0, we}, 32'd0);
      chk($sformatf("rst%0d_count", i), {29'd0, cnt}, 32'd0);
      chk($sformatf("rst%0d_ready", i), {31'd0, lrdy}, 32'd0);
      chk($sformatf("rst%0d_hazard", i), {31'd0, haz}, 32'd0);
    end
    idle_inputs();
    rst_n = 1;
    chk("release_ready_before_edge", {31'd0, lrdy}, 32'd0);

    foreach (vecs[i]) apply(vecs[i], i);

    apply(mk(1, 1, 32'd100, 0, 0, 0,          1, 20, 20, 0, 0,  1, 1, 32'd100, 0, 1, 1), 100);
    apply(mk(1, 1, 32'd101, 1, 20, 32'd200,   1, 21, 20, 21, 0, 1, 1, 32'd101, 1, 1, 1), 101);
    apply(mk(1, 1, 32'd102, 1, 21, 32'd201,   0, 0,  0, 21, 0,  1, 1, 32'd102, 2, 1, 1), 102);
    apply(mk(1, 1, 32'd103, 1, 22, 32'd202,   0, 0,  20, 0, 0,  1, 1, 32'd103, 3, 1, 1), 103);
    idle_inputs();
    c1 = 20; c2 = 21;
    #2 rst_n = 0;
    sb.delete();
    #1;
    chk("midrst_regwrite", {31'd0, we}, 32'd0);
    chk("midrst_count", {29'd0, cnt}, 32'd0);
    chk("midrst_ready", {31'd0, lrdy}, 32'd0);
    chk("midrst_hazard", {31'd0, haz}, 32'd0);
    chk("midrst_wreg", {27'd0, wreg}, 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post%0d_regwrite", i), {31'd0, we}, 32'd0);
      chk($sformatf("post%0d_count", i), {29'd0, cnt}, 32'd0);
      chk($sformatf("post%0d_ready", i), {31'd0, lrdy}, 32'd1);
      chk($sformatf("post%0d_hazard", i), {31'd0, haz}, 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
